ddrx_wr_strobe_sched: RTL and testbench

DDRX_WR_STROBE_SCHED -- requirements
Module: ddrx_wr_strobe_sched

---
 rtl/ddrx_wr_strobe_sched.sv | 205 ++++++++++++++++++++
 tb/tb_ddrx_wr_strobe_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ddrx_wr_strobe_sched.sv
// ddrx_wr_strobe_sched: DDR write DQS/DQ enable scheduler.
// A base IDLE/PRE/DATA/POST sequence is generated once, then replayed per
// byte lane through a delay pipeline selected by that lane's delay code.
// Optional feature: define DDRX_SCHED_STATS_EN to add the burst_cnt output.
module ddrx_wr_strobe_sched #(
    parameter int NUM_LANES = 8,
    parameter int BURST_LEN = 8,
    parameter int DLY_W     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [1:0]                    cfg_preamble,
    input  logic                          cfg_postamble,
    input  logic [NUM_LANES*DLY_W-1:0]    cfg_lane_dly,
    output logic [NUM_LANES-1:0]          dqs_oe,
    output logic [NUM_LANES-1:0]          dqs_toggle,
    output logic [NUM_LANES-1:0]          dq_oe,
    output logic [$clog2(BURST_LEN/2)-1:0] beat_idx,
    output logic                          busy
`ifdef DDRX_SCHED_STATS_EN
    ,
    output logic [15:0]                   burst_cnt
`endif
);

    localparam int BEATS  = BURST_LEN / 2;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int DEPTH  = (1 << DLY_W) - 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Base signal bundle: {dqs_oe, dqs_toggle, dq_oe}
    localparam logic [2:0] BASE_OFF  = 3'b000;
    localparam logic [2:0] BASE_PRE  = 3'b100;
    localparam logic [2:0] BASE_DATA = 3'b111;
    localparam logic [2:0] BASE_POST = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_POST
    } state_t;

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic                r_post;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_wr_ready;
    logic [2:0]          r_base;
    logic [DLY_W-1:0]    r_dly  [NUM_LANES];
    logic [2:0]          r_pipe [NUM_LANES][DEPTH];

    logic                w_hs;
    logic                w_pipe_any;
    logic [NUM_LANES-1:0] w_oe;
    logic [NUM_LANES-1:0] w_tog;
    logic [NUM_LANES-1:0] w_dq;

    assign w_hs = wr_valid & r_wr_ready;

    // Base schedule FSM with registered base signals, beat index and ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_post     <= 1'b0;
            r_beat     <= '0;
            r_wr_ready <= 1'b0;
            r_base     <= BASE_OFF;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wr_ready <= 1'b1;
                    r_base     <= BASE_OFF;
                    r_beat     <= '0;
                    if (w_hs) begin
                        r_state    <= S_PRE;
                        r_cnt      <= (cfg_preamble == 2'd0) ? 2'd0 : cfg_preamble - 2'd1;
                        r_post     <= cfg_postamble;
                        r_wr_ready <= 1'b0;
                        r_base     <= BASE_PRE;
                        for (int unsigned i = 0; i < NUM_LANES; i++) begin
                            r_dly[i] <= cfg_lane_dly[i*DLY_W +: DLY_W];
                        end
                    end
                end
                S_PRE: begin
                    if (r_cnt == 2'd0) begin
                        r_state    <= S_DATA;
                        r_beat     <= '0;
                        r_base     <= BASE_DATA;
                        r_wr_ready <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_DATA: begin
                    if (r_beat == LAST_BEAT) begin
                        r_beat     <= '0;
                        r_wr_ready <= 1'b0;
                        if (!w_hs) begin
                            // No back-to-back request: close with the postamble
                            r_state <= S_POST;
                            r_cnt   <= {1'b0, r_post};
                            r_base  <= BASE_POST;
                        end
                    end else begin
                        r_beat     <= r_beat + BEAT_W'(1);
                        r_wr_ready <= ((r_beat + BEAT_W'(1)) == LAST_BEAT);
                    end
                end
                S_POST: begin
                    if (r_cnt == 2'd0) begin
                        r_state    <= S_IDLE;
                        r_base     <= BASE_OFF;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_base     <= BASE_OFF;
                    r_wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane delay pipelines; stages beyond the lane's tap are held at zero
    // so that busy reflects only bits still on their way to a lane output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    r_pipe[i][k] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                r_pipe[i][0] <= (r_dly[i] != '0) ? r_base : 3'b000;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    if (k < 32'(r_dly[i])) begin
                        r_pipe[i][k] <= r_pipe[i][k-1];
                    end else begin
                        r_pipe[i][k] <= '0;
                    end
                end
            end
        end
    end

    // Lane output tap select: code 0 passes the registered base straight through
    always_comb begin
        w_oe  = '0;
        w_tog = '0;
        w_dq  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (r_dly[i] == '0) begin
                {w_oe[i], w_tog[i], w_dq[i]} = r_base;
            end else begin
                {w_oe[i], w_tog[i], w_dq[i]} = r_pipe[i][r_dly[i] - DLY_W'(1)];
            end
        end
    end

    // Any enable bit still in flight in a lane pipeline keeps busy asserted
    always_comb begin
        w_pipe_any = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                w_pipe_any = w_pipe_any | (|r_pipe[i][k]);
            end
        end
    end

    assign dqs_oe     = w_oe;
    assign dqs_toggle = w_tog;
    assign dq_oe      = w_dq;
    assign beat_idx   = r_beat;
    assign wr_ready   = r_wr_ready;
    assign busy       = (r_state != S_IDLE) | w_pipe_any;

`ifdef DDRX_SCHED_STATS_EN
    logic [15:0] r_burst_cnt;

    // Saturating count of accepted bursts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else if (w_hs && (r_burst_cnt != '1)) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
        end
    end

    assign burst_cnt = r_burst_cnt;
`endif

endmodule

// File: tb/tb_ddrx_wr_strobe_sched.sv
// Directed self-checking bench for ddrx_wr_strobe_sched (default parameters).
module tb_ddrx_wr_strobe_sched;

    localparam int NL = 8;
    localparam int DW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid;
    logic            wr_ready;
    logic [1:0]      cfg_preamble;
    logic            cfg_postamble;
    logic [NL*DW-1:0] cfg_lane_dly;
    logic [NL-1:0]   dqs_oe;
    logic [NL-1:0]   dqs_toggle;
    logic [NL-1:0]   dq_oe;
    logic [1:0]      beat_idx;
    logic            busy;
`ifdef DDRX_SCHED_STATS_EN
    logic [15:0]     burst_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Captured 16-cycle traces, bit n = sample n clocks after the first handshake
    logic [15:0] v_oe0, v_tg0, v_dq0, v_oe3, v_tg3, v_dq3, v_busy, v_rdy;
    logic [31:0] v_beat;
    logic [31:0] exp_beat;

    ddrx_wr_strobe_sched #(
        .NUM_LANES (NL),
        .BURST_LEN (8),
        .DLY_W     (DW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .cfg_preamble  (cfg_preamble),
        .cfg_postamble (cfg_postamble),
        .cfg_lane_dly  (cfg_lane_dly),
        .dqs_oe        (dqs_oe),
        .dqs_toggle    (dqs_toggle),
        .dq_oe         (dq_oe),
        .beat_idx      (beat_idx),
        .busy          (busy)
`ifdef DDRX_SCHED_STATS_EN
        ,
        .burst_cnt     (burst_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request one burst now (DUT idle) and record 16 cycles of lane 0/3 activity
    task automatic run_burst(input int drop_at, input int chg_at, input logic [NL*DW-1:0] chg_val);
        wr_valid = 1'b1;
        v_oe0 = '0; v_tg0 = '0; v_dq0 = '0;
        v_oe3 = '0; v_tg3 = '0; v_dq3 = '0;
        v_busy = '0; v_rdy = '0; v_beat = '0;
        for (int n = 0; n < 16; n++) begin
            tick();
            v_oe0[n]  = dqs_oe[0];
            v_tg0[n]  = dqs_toggle[0];
            v_dq0[n]  = dq_oe[0];
            v_oe3[n]  = dqs_oe[3];
            v_tg3[n]  = dqs_toggle[3];
            v_dq3[n]  = dq_oe[3];
            v_busy[n] = busy;
            v_rdy[n]  = wr_ready;
            v_beat[2*n +: 2] = beat_idx;
            if (n == drop_at) wr_valid = 1'b0;
            if (n == chg_at) cfg_lane_dly = chg_val;
        end
    endtask

    task automatic verify(input string t,
                          input logic [15:0] e_oe0, input logic [15:0] e_tg0,
                          input logic [15:0] e_oe3, input logic [15:0] e_tg3,
                          input logic [15:0] e_busy, input logic [15:0] e_rdy,
                          input logic [31:0] e_beat);
        check({t, ".oe0"},  32'(v_oe0),  32'(e_oe0));
        check({t, ".tg0"},  32'(v_tg0),  32'(e_tg0));
        check({t, ".dq0"},  32'(v_dq0),  32'(e_tg0));
        check({t, ".oe3"},  32'(v_oe3),  32'(e_oe3));
        check({t, ".tg3"},  32'(v_tg3),  32'(e_tg3));
        check({t, ".dq3"},  32'(v_dq3),  32'(e_tg3));
        check({t, ".busy"}, 32'(v_busy), 32'(e_busy));
        check({t, ".rdy"},  32'(v_rdy),  32'(e_rdy));
        check({t, ".beat"}, v_beat,      e_beat);
    endtask

    initial begin
        rst           = 1'b1;
        wr_valid      = 1'b0;
        cfg_preamble  = 2'd1;
        cfg_postamble = 1'b0;
        cfg_lane_dly  = '0;

        tick();
        tick();
        check("rst.oe",   32'(dqs_oe),     32'h0);
        check("rst.tg",   32'(dqs_toggle), 32'h0);
        check("rst.dq",   32'(dq_oe),      32'h0);
        check("rst.rdy",  32'(wr_ready),   32'h0);
        check("rst.busy", 32'(busy),       32'h0);
        check("rst.beat", 32'(beat_idx),   32'h0);
        rst = 1'b0;
        tick();
        check("rel.rdy", 32'(wr_ready), 32'h1);

        // Single burst, preamble 1, postamble 1 clock, no lane delay
        run_burst(0, -1, '0);
        verify("t1", 16'h003F, 16'h001E, 16'h003F, 16'h001E,
               16'h003F, 16'hFFD0, 32'h0000_0390);

        // Preamble 2, postamble 2 clocks, lane 3 delayed by 5 clocks
        cfg_preamble  = 2'd2;
        cfg_postamble = 1'b1;
        cfg_lane_dly  = 24'h000A00;
        run_burst(0, -1, '0);
        verify("t2", 16'h00FF, 16'h003C, 16'h1FE0, 16'h0780,
               16'h1FFF, 16'hFF20, 32'h0000_0E40);

        // Three seamless bursts with wr_valid held across the handshakes
        cfg_preamble  = 2'd1;
        cfg_postamble = 1'b0;
        cfg_lane_dly  = '0;
        exp_beat = '0;
        for (int n = 1; n <= 12; n++) exp_beat[2*n +: 2] = 2'((n - 1) % 4);
        run_burst(9, -1, '0);
        verify("t3", 16'h3FFF, 16'h1FFE, 16'h3FFF, 16'h1FFE,
               16'h3FFF, 16'hD110, exp_beat);

        // Reset asserted mid-burst at beat 2
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t4.beat_pre", 32'(beat_idx), 32'h2);
        check("t4.oe_pre",   32'(dqs_oe),   32'hFF);
        #1 rst = 1'b1;
        #1;
        check("t4.oe",   32'(dqs_oe),     32'h0);
        check("t4.tg",   32'(dqs_toggle), 32'h0);
        check("t4.dq",   32'(dq_oe),      32'h0);
        check("t4.busy", 32'(busy),       32'h0);
        check("t4.rdy",  32'(wr_ready),   32'h0);
        check("t4.beat", 32'(beat_idx),   32'h0);
`ifdef DDRX_SCHED_STATS_EN
        check("t4.cnt", 32'(burst_cnt), 32'h0);
`endif
        tick();
        rst = 1'b0;
        tick();
        check("t4.rel_rdy",  32'(wr_ready), 32'h1);
        check("t4.rel_busy", 32'(busy),     32'h0);

        // Preamble code 0 behaves as 1; wr_valid held into PRE/early DATA is ignored
        cfg_preamble  = 2'd0;
        cfg_postamble = 1'b0;
        cfg_lane_dly  = '0;
        run_burst(2, -1, '0);
        verify("t5a", 16'h003F, 16'h001E, 16'h003F, 16'h001E,
               16'h003F, 16'hFFD0, 32'h0000_0390);

        // Lane delay changed during DATA leaves the running burst unchanged
        cfg_preamble  = 2'd2;
        cfg_postamble = 1'b1;
        cfg_lane_dly  = 24'h000A00;
        run_burst(0, 3, '0);
        verify("t5b", 16'h00FF, 16'h003C, 16'h1FE0, 16'h0780,
               16'h1FFF, 16'hFF20, 32'h0000_0E40);

`ifdef DDRX_SCHED_STATS_EN
        check("cnt.after_rst", 32'(burst_cnt), 32'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
